// File: rtl/gpio_led.sv
// gpio_led: free-running waterfall pattern generator for an 8-bit LED bank.
// A prescaler divides clk down to one step tick every STEP_CYCLES clocks.
// Each tick advances a four-phase sequencer through 32 patterns:
// shift left, shift right, fill bar, alternating blink. The sequence then repeats.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset; led returns to 8'h01 at once
//   led    registered LED drive, active-high
module gpio_led #(
    parameter int unsigned STEP_CYCLES = 25_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] led
);

    localparam int unsigned CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);

    typedef enum logic [1:0] {
        SHIFT_L = 2'd0,
        SHIFT_R = 2'd1,
        FILL    = 2'd2,
        BLINK   = 2'd3
    } phase_t;

    logic [CNT_W-1:0] cnt;
    logic             tick;
    phase_t           phase;
    phase_t           phase_nxt;
    logic [2:0]       idx;
    logic [2:0]       idx_nxt;
    logic [7:0]       pattern;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            phase <= SHIFT_L;
            idx   <= '0;
            led   <= 8'h01;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick) begin
                phase <= phase_nxt;
                idx   <= idx_nxt;
                led   <= pattern;
            end
        end
    end

    // The LED register takes the pattern of the step being entered.
    // It therefore changes on the same edge where the prescaler wraps.
    always_comb begin
        tick      = (cnt == CNT_LAST);
        phase_nxt = phase;
        idx_nxt   = idx;
        pattern   = 8'h01;

        if (tick) begin
            idx_nxt = idx + 3'd1;
            if (idx == 3'd7) begin
                case (phase)
                    SHIFT_L: phase_nxt = SHIFT_R;
                    SHIFT_R: phase_nxt = FILL;
                    FILL:    phase_nxt = BLINK;
                    BLINK:   phase_nxt = SHIFT_L;
                    default: phase_nxt = SHIFT_L;
                endcase
            end
        end

        case (phase_nxt)
            SHIFT_L: pattern = 8'h01 << idx_nxt;
            SHIFT_R: pattern = 8'h80 >> idx_nxt;
            // At idx 7 the shift overflows 8 bits to zero.
            // The subtraction then wraps to 8'hFF, the full bar.
            FILL:    pattern = (8'h02 << idx_nxt) - 8'h01;
            BLINK:   pattern = idx_nxt[0] ? 8'h55 : 8'hAA;
            default: pattern = 8'h01 << idx_nxt;
        endcase
    end

endmodule

// File: tb/tb_gpio_led.sv
// tb_gpio_led: self-checking bench for gpio_led.
// It drives two instances, one with STEP_CYCLES=4 and one with STEP_CYCLES=1.
// Expected patterns come from a step-number reference model and a fixed table.
module tb_gpio_led;

    logic       clk = 1'b0;
    logic       rst4 = 1'b0;
    logic       rst1 = 1'b0;
    logic [7:0] led4;
    logic [7:0] led1;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned since4 = 0;
    int unsigned since1 = 0;

    typedef struct {
        int unsigned tick;
        logic [7:0]  led;
    } vec_t;

    vec_t vecs [32];

    gpio_led #(.STEP_CYCLES(4)) dut4 (
        .clk   (clk),
        .rst_n (rst4),
        .led   (led4)
    );

    gpio_led #(.STEP_CYCLES(1)) dut1 (
        .clk   (clk),
        .rst_n (rst1),
        .led   (led1)
    );

    always #5 clk = ~clk;

    // Pattern for absolute step number: 8 steps per phase, 4 phases per loop.
    function automatic logic [7:0] exp_led(input int unsigned step);
        int unsigned n;
        int unsigned p;
        int unsigned i;
        n = step % 32;
        p = n / 8;
        i = n % 8;
        case (p)
            0:       return 8'(1 << i);
            1:       return 8'(128 >> i);
            2:       return 8'((1 << (i + 1)) - 1);
            default: return (i % 2 == 1) ? 8'h55 : 8'hAA;
        endcase
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: led=%h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance n clocks on the STEP_CYCLES=4 instance.
    // After every rising edge, compare led4 against the model.
    task automatic step4(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            @(negedge clk);
            since4++;
            check("model4", led4, exp_led(since4 / 4));
        end
    endtask

    initial begin
        logic [7:0] seq [32];
        seq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h80,
                8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h01,
                8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'hAA,
                8'h55, 8'hAA, 8'h55, 8'hAA, 8'h55, 8'hAA, 8'h55, 8'h01};
        for (int k = 0; k < 32; k++) begin
            vecs[k].tick = 32'(k + 1);
            vecs[k].led  = seq[k];
        end

        // Hold reset for 100 ns with the clock running.
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("reset_hold4", led4, 8'h01);
            check("reset_hold1", led1, 8'h01);
        end

        // Release reset and step through the first full period from the table.
        rst4 = 1'b1;
        since4 = 0;
        for (int k = 0; k < 32; k++) begin
            step4(3);
            @(negedge clk);
            since4++;
            check($sformatf("table_tick%0d", vecs[k].tick), led4, vecs[k].led);
        end

        // Two more periods; led must be 01 exactly at clocks 256 and 384.
        step4(128);
        check("wrap256", led4, 8'h01);
        step4(128);
        check("wrap384", led4, 8'h01);

        // Reset during FILL while led=1F, asserted between clock edges.
        step4(82);
        check("fill_1f", led4, 8'h1F);
        #2;
        rst4 = 1'b0;
        #1;
        check("async_reset", led4, 8'h01);
        @(negedge clk);
        check("reset_mid", led4, 8'h01);
        rst4 = 1'b1;
        since4 = 0;
        step4(3);
        @(negedge clk);
        since4++;
        check("after_reset_edge4", led4, 8'h02);

        // Randomized run lengths and reset points against the model.
        for (int r = 0; r < 20; r++) begin
            step4($urandom_range(1, 150));
            #($urandom_range(1, 4));
            rst4 = 1'b0;
            #1;
            check("rand_async_reset", led4, 8'h01);
            @(negedge clk);
            check("rand_reset_hold", led4, 8'h01);
            rst4 = 1'b1;
            since4 = 0;
        end
        step4(40);

        // Degenerate prescaler: the pattern advances on every clock.
        check("deg_reset", led1, 8'h01);
        rst1 = 1'b1;
        since1 = 0;
        for (int k = 0; k < 70; k++) begin
            @(negedge clk);
            since1++;
            check("degenerate", led1, exp_led(since1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
